// File: rtl/flopenr_pipe.sv
// DEPTH-stage elastic pipeline register with a valid/ready handshake, a global enable and a synchronous flush.
// Defining FLOPENR_PIPE_OCC_EN adds the occ port, which reports how many stages hold a beat.

module flopenr_pipe_stage #(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             rdy_i,
  input  logic             up_vld_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (clr_i) vld_d = 1'b0;
    else if (rdy_i) begin
      vld_d = up_vld_i;
      // A bubble moving through the stage does not toggle the data flops
      if (up_vld_i) data_d = up_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      data_q <= RESET_VAL;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
endmodule

module flopenr_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef FLOPENR_PIPE_OCC_EN
  ,output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);
  if (DEPTH < 1) begin : g_bad_depth
    $error("flopenr_pipe: DEPTH must be at least 1");
  end

  logic [DEPTH:0]                rdy;
  logic [DEPTH-1:0]              vld_q;
  logic [DEPTH-1:0][WIDTH-1:0]   data_q;
  logic [DEPTH-1:0]              up_vld;
  logic [DEPTH-1:0][WIDTH-1:0]   up_data;
  logic                          clr;

  assign clr = en & flush;

  // A stage can take a beat when it is empty or its occupant moves on this cycle
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--)
      rdy[i] = en & ~flush & (~vld_q[i] | rdy[i+1]);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    if (i == 0) begin : g_head
      assign up_vld[i]  = in_valid;
      assign up_data[i] = in_data;
    end else begin : g_body
      assign up_vld[i]  = vld_q[i-1];
      assign up_data[i] = data_q[i-1];
    end

    flopenr_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stg (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr),
      .rdy_i     (rdy[i]),
      .up_vld_i  (up_vld[i]),
      .up_data_i (up_data[i]),
      .vld_o     (vld_q[i]),
      .data_o    (data_q[i])
    );
  end

  // Stages are empty under reset, so rst also masks in_ready while it is held
  assign in_ready  = rdy[0] & rst;
  assign out_valid = vld_q[DEPTH-1] & en & ~flush;
  assign out_data  = data_q[DEPTH-1];

`ifdef FLOPENR_PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);
  logic [OW-1:0] occ_cnt;

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < DEPTH; i++) occ_cnt = occ_cnt + OW'(vld_q[i]);
  end

  assign occ = occ_cnt;
`endif
endmodule

// File: tb/tb_flopenr_pipe.sv
// Bench for flopenr_pipe: runs a DEPTH=3 and a DEPTH=1 instance side by side against a slot-based model and scoreboards.
// Define FLOPENR_PIPE_OCC_EN to have the occupancy port checked as well.

module tb_flopenr_pipe;
  logic       clk = 1'b0;
  logic       rst, en, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       ir3, ov3, ir1, ov1;
  logic [7:0] od3, od1;
`ifdef FLOPENR_PIPE_OCC_EN
  logic [1:0] occ3;
  logic       occ1;
`endif

  always #5 clk = ~clk;

  flopenr_pipe #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_ready(out_ready)
`ifdef FLOPENR_PIPE_OCC_EN
    ,.occ(occ3)
`endif
  );

  flopenr_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready)
`ifdef FLOPENR_PIPE_OCC_EN
    ,.occ(occ1)
`endif
  );

  int chk_cnt = 0;
  int pass_cnt = 0;

  // slot[k][i] = data of the beat held at position i of instance k, -1 when empty
  int         slot [2][3];
  int         dep  [2] = '{3, 1};
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int cnt(input int k);
    int n = 0;
    for (int i = 0; i < dep[k]; i++) if (slot[k][i] >= 0) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) for (int i = 0; i < 3; i++) slot[k][i] = -1;
    q0.delete();
    q1.delete();
  endtask

  // One clock edge of the model: the head beat leaves, beats slide up into holes, the input enters slot 0
  task automatic step(input int k, input bit iv, input logic [7:0] id, input bit e, input bit f, input bit r);
    int d = dep[k];
    if (!e) return;
    if (f) begin
      for (int i = 0; i < d; i++) slot[k][i] = -1;
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end
    if (r) slot[k][d-1] = -1;
    for (int i = d - 1; i >= 1; i--)
      if (slot[k][i] < 0) begin
        slot[k][i]   = slot[k][i-1];
        slot[k][i-1] = -1;
      end
    if (slot[k][0] < 0 && iv) begin
      slot[k][0] = int'(id);
      if (k == 0) q0.push_back(id); else q1.push_back(id);
    end
  endtask

  task automatic cyc(input bit iv, input logic [7:0] id, input bit e, input bit f, input bit r);
    bit exp_ir, exp_ov;
    @(negedge clk);
    in_valid = iv; in_data = id; en = e; flush = f; out_ready = r;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_ir = e && !f && (cnt(k) < dep[k] || r);
      exp_ov = e && !f && (slot[k][dep[k]-1] >= 0);
      chk(k == 0 ? "in_ready_d3" : "in_ready_d1", k == 0 ? int'(ir3) : int'(ir1), int'(exp_ir));
      chk(k == 0 ? "out_valid_d3" : "out_valid_d1", k == 0 ? int'(ov3) : int'(ov1), int'(exp_ov));
`ifdef FLOPENR_PIPE_OCC_EN
      chk(k == 0 ? "occ_d3" : "occ_d1", k == 0 ? int'(occ3) : int'(occ1), cnt(k));
`endif
      step(k, iv, id, e, f, r);
    end
  endtask

  task automatic reset_check();
    rst = 1'b0;
    #1;
    chk("rst_out_valid_d3", int'(ov3), 0);
    chk("rst_out_data_d3", int'(od3), 0);
    chk("rst_in_ready_d3", int'(ir3), 0);
    chk("rst_out_valid_d1", int'(ov1), 0);
    chk("rst_out_data_d1", int'(od1), 0);
    chk("rst_in_ready_d1", int'(ir1), 0);
`ifdef FLOPENR_PIPE_OCC_EN
    chk("rst_occ_d3", int'(occ3), 0);
    chk("rst_occ_d1", int'(occ1), 0);
`endif
    model_clear();
  endtask

  task automatic reset_pulse();
    #2;
    reset_check();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Output-side scoreboard: every emitted beat must be the oldest accepted one
  logic [7:0] exp_d;
  always begin
    @(negedge clk);
    #2;
    if (rst && ov3 && out_ready) begin
      if (q0.size() == 0) chk("sb_underflow_d3", 0, 1);
      else begin exp_d = q0.pop_front(); chk("sb_data_d3", int'(od3), int'(exp_d)); end
    end
    if (rst && ov1 && out_ready) begin
      if (q1.size() == 0) chk("sb_underflow_d1", 0, 1);
      else begin exp_d = q1.pop_front(); chk("sb_data_d1", int'(od1), int'(exp_d)); end
    end
  end

  logic [7:0] pat [4];

  initial begin
    rst = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    model_clear();
    #1;
    reset_check();
    @(negedge clk);
    rst = 1'b1;

    // reset asserted mid-cycle with beats in flight and the input still driving
    cyc(1, 8'hFF, 1, 0, 0);
    cyc(1, 8'hFF, 1, 0, 0);
    reset_pulse();

    // streaming
    cyc(1, 8'hAA, 1, 0, 1);
    cyc(1, 8'h55, 1, 0, 1);
    cyc(1, 8'hC3, 1, 0, 1);
    repeat (4) cyc(0, 8'h00, 1, 0, 1);

    // back-pressure until full, then simultaneous in and out transfer
    cyc(1, 8'h11, 1, 0, 0);
    cyc(1, 8'h22, 1, 0, 0);
    cyc(1, 8'h33, 1, 0, 0);
    cyc(1, 8'h44, 1, 0, 0);
    cyc(1, 8'h44, 1, 0, 1);
    repeat (5) cyc(0, 8'h00, 1, 0, 1);

    // enable stall with two beats in flight
    cyc(1, 8'h5A, 1, 0, 1);
    cyc(1, 8'hA5, 1, 0, 1);
    repeat (4) cyc(1, 8'h77, 0, 0, 1);
    repeat (5) cyc(0, 8'h00, 1, 0, 1);

    // flush with three beats held and a competing input
    cyc(1, 8'h01, 1, 0, 0);
    cyc(1, 8'h02, 1, 0, 0);
    cyc(1, 8'h03, 1, 0, 0);
    cyc(1, 8'h99, 1, 1, 1);
    repeat (5) cyc(0, 8'h00, 1, 0, 1);

    // data corner values
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h80; pat[3] = 8'h01;
    for (int i = 0; i < 4; i++) cyc(1, pat[i], 1, 0, 1);
    repeat (5) cyc(0, 8'h00, 1, 0, 1);

    // random traffic with an embedded reset
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) != 0,
          $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0);
      if (i == 300) reset_pulse();
    end

    repeat (6) cyc(0, 8'h00, 1, 0, 1);
    chk("drained_d3", q0.size(), 0);
    chk("drained_d1", q1.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
